ibex_rf_access_ctrl: RTL and testbench

//  Sequencer/arbiter for the write port and read port B of the latch register file. After reset it

---
 rtl/ibex_rf_access_ctrl_pkg.sv | 17 +
 rtl/ibex_rf_access_ctrl.sv | 127 ++++++++++++
 tb/tb_ibex_rf_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_rf_access_ctrl_pkg.sv
// Shared types for the register-file access sequencer: FSM state encoding
// and register-count helper.
package ibex_rf_access_ctrl_pkg;

  typedef enum logic [1:0] {
    RF_CLEAR,
    RF_RUN,
    RF_DBG_RD
  } rf_ctrl_state_e;

  localparam int unsigned RegAddrW = 5;

  function automatic int unsigned num_regs(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_access_ctrl.sv
// Write-port / read-port-B sequencer for the latch register file: post-reset
// clear sweep, core pass-through, and a debug req/gnt access path while halted.
module ibex_rf_access_ctrl
  import ibex_rf_access_ctrl_pkg::*;
#(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  parameter bit                   ClearOnReset = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_halted_i,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic [4:0]           core_raddr_b_i,
  input  logic                 dbg_req_i,
  input  logic                 dbg_we_i,
  input  logic [4:0]           dbg_addr_i,
  input  logic [DataWidth-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  output logic                 dbg_rvalid_o,
  output logic [DataWidth-1:0] dbg_rdata_o,
  output logic                 dbg_err_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [4:0]           rf_raddr_b_o,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic                 init_done_o,
  output logic                 err_o
);

  localparam int unsigned         NumRegs = num_regs(RV32E);
  localparam logic [RegAddrW-1:0] LastReg = RegAddrW'(NumRegs - 1);

  rf_ctrl_state_e        r_state;
  logic [RegAddrW-1:0]   r_clr_cnt;
  logic                  r_init_done;
  logic                  r_err;
  logic                  r_dbg_rvalid;
  logic                  r_dbg_err;
  logic [DataWidth-1:0]  r_dbg_rdata;

  logic w_dbg_illegal;
  logic w_dbg_no_write;
  logic w_dbg_gnt;

  assign w_dbg_illegal  = RV32E && dbg_addr_i[4];
  assign w_dbg_no_write = w_dbg_illegal || (dbg_addr_i == '0);

  // Core traffic always wins; a pending read result also blocks the next grant.
  assign w_dbg_gnt = (r_state == RF_RUN) && dbg_req_i && core_halted_i &&
                     !core_we_i && !r_dbg_rvalid;

  always_comb begin
    rf_we_o      = core_we_i;
    rf_waddr_o   = core_waddr_i;
    rf_wdata_o   = core_wdata_i;
    rf_raddr_b_o = core_raddr_b_i;
    case (r_state)
      RF_CLEAR: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_clr_cnt;
        rf_wdata_o = WordZeroVal;
      end
      RF_RUN: begin
        if (w_dbg_gnt) begin
          if (dbg_we_i) begin
            rf_we_o    = !w_dbg_no_write;
            rf_waddr_o = dbg_addr_i;
            rf_wdata_o = dbg_wdata_i;
          end else begin
            rf_raddr_b_o = dbg_addr_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ClearOnReset ? RF_CLEAR : RF_RUN;
      r_clr_cnt    <= RegAddrW'(1);
      r_init_done  <= !ClearOnReset;
      r_err        <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_dbg_rvalid <= 1'b0;
      r_dbg_err    <= 1'b0;
      case (r_state)
        RF_CLEAR: begin
          if (core_we_i) r_err <= 1'b1;
          r_clr_cnt <= r_clr_cnt + RegAddrW'(1);
          if (r_clr_cnt == LastReg) begin
            r_state     <= RF_RUN;
            r_init_done <= 1'b1;
          end
        end
        RF_RUN: begin
          if (w_dbg_gnt) begin
            r_dbg_err <= w_dbg_illegal;
            if (!dbg_we_i) begin
              r_dbg_rvalid <= 1'b1;
              r_dbg_rdata  <= w_dbg_no_write ? WordZeroVal : rf_rdata_b_i;
              r_state      <= RF_DBG_RD;
            end
          end
        end
        RF_DBG_RD: r_state <= RF_RUN;
        default:   r_state <= RF_CLEAR;
      endcase
    end
  end

  assign dbg_gnt_o    = w_dbg_gnt;
  assign dbg_rvalid_o = r_dbg_rvalid;
  assign dbg_rdata_o  = r_dbg_rdata;
  assign dbg_err_o    = r_dbg_err;
  assign init_done_o  = r_init_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_ibex_rf_access_ctrl.sv
// Directed bench for ibex_rf_access_ctrl: a 32-register instance backed by a
// small RF model and a 16-register instance with a non-zero clear value.
module tb_ibex_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halted;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic [4:0]  core_raddr;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;

  logic        a_gnt, a_rvalid, a_derr, a_we, a_done, a_err;
  logic [31:0] a_rdata, a_wdata, a_rf_rdata;
  logic [4:0]  a_waddr, a_raddr;

  logic        e_gnt, e_rvalid, e_derr, e_we, e_done, e_err;
  logic [31:0] e_rdata, e_wdata, e_rf_rdata;
  logic [4:0]  e_waddr, e_raddr;

  logic [31:0] mem [32];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [31:0] EZero = 32'hA5A5_0000;

  always #5 clk = ~clk;

  ibex_rf_access_ctrl #(
    .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .ClearOnReset(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .core_halted_i(halted),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .core_raddr_b_i(core_raddr), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(a_gnt),
    .dbg_rvalid_o(a_rvalid), .dbg_rdata_o(a_rdata), .dbg_err_o(a_derr),
    .rf_we_o(a_we), .rf_waddr_o(a_waddr), .rf_wdata_o(a_wdata),
    .rf_raddr_b_o(a_raddr), .rf_rdata_b_i(a_rf_rdata),
    .init_done_o(a_done), .err_o(a_err)
  );

  ibex_rf_access_ctrl #(
    .RV32E(1'b1), .DataWidth(32), .WordZeroVal(EZero), .ClearOnReset(1'b1)
  ) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n), .core_halted_i(halted),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .core_raddr_b_i(core_raddr), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(e_gnt),
    .dbg_rvalid_o(e_rvalid), .dbg_rdata_o(e_rdata), .dbg_err_o(e_derr),
    .rf_we_o(e_we), .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata),
    .rf_raddr_b_o(e_raddr), .rf_rdata_b_i(e_rf_rdata),
    .init_done_o(e_done), .err_o(e_err)
  );

  // Register file model for instance A; reset fills a non-zero pattern so the sweep is visible.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hFFFF_0000 | 32'(i);
    end else if (a_we) begin
      mem[a_waddr] <= a_wdata;
    end
  end
  assign a_rf_rdata = mem[a_raddr];
  assign e_rf_rdata = 32'hCAFE_F00D;

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halted = 1'b0; core_we = 1'b0; core_waddr = '0; core_wdata = '0;
    core_raddr = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    #1;
    chk1("rst_gnt", a_gnt, 1'b0);
    chk1("rst_rvalid", a_rvalid, 1'b0);
    chkw("rst_rdata", a_rdata, 32'h0);
    chk1("rst_dbg_err", a_derr, 1'b0);
    chk1("rst_init_done", a_done, 1'b0);
    chk1("rst_err", a_err, 1'b0);
    tick();
    rst_n = 1'b1;

    // Initial sweep with a core write attempt in sweep cycle 5
    for (int c = 1; c <= 31; c++) begin
      if (c == 5) begin
        core_we = 1'b1; core_waddr = 5'd7; core_wdata = 32'h1234;
      end else begin
        core_we = 1'b0;
      end
      #1;
      chk1($sformatf("sweep_we_%0d", c), a_we, 1'b1);
      chkw($sformatf("sweep_waddr_%0d", c), 32'(a_waddr), 32'(c));
      chkw($sformatf("sweep_wdata_%0d", c), a_wdata, 32'h0);
      chk1($sformatf("sweep_done_%0d", c), a_done, 1'b0);
      if (c == 6) chk1("err_set", a_err, 1'b1);
      if (c == 15) begin
        chkw("e_last_waddr", 32'(e_waddr), 32'd15);
        chkw("e_last_wdata", e_wdata, EZero);
        chk1("e_done_before", e_done, 1'b0);
      end
      if (c == 16) begin
        chk1("e_done_after", e_done, 1'b1);
        chk1("e_run_we", e_we, 1'b0);
      end
      tick();
    end
    #1;
    chk1("a_done_after", a_done, 1'b1);
    chk1("a_err_sticky", a_err, 1'b1);
    chk1("e_err_sticky", e_err, 1'b1);
    chk1("a_run_we_idle", a_we, 1'b0);
    chkw("a_x1_cleared", mem[1], 32'h0);
    chkw("a_x31_cleared", mem[31], 32'h0);
    chkw("a_x0_untouched", mem[0], 32'hFFFF_0000);
    tick();

    // Core pass-through; debug request ignored while not halted
    core_we = 1'b1; core_waddr = 5'd9; core_wdata = 32'h55; core_raddr = 5'd3;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("pt_we", a_we, 1'b1);
    chkw("pt_waddr", 32'(a_waddr), 32'd9);
    chkw("pt_wdata", a_wdata, 32'h55);
    chkw("pt_raddr", 32'(a_raddr), 32'd3);
    chk1("pt_gnt_unhalted", a_gnt, 1'b0);
    tick();

    halted = 1'b1;
    #1;
    chk1("core_wins_gnt", a_gnt, 1'b0);
    chkw("core_wins_waddr", 32'(a_waddr), 32'd9);
    tick();

    core_we = 1'b0;
    #1;
    chk1("dbgw_gnt", a_gnt, 1'b1);
    chk1("dbgw_we", a_we, 1'b1);
    chkw("dbgw_waddr", 32'(a_waddr), 32'd5);
    chkw("dbgw_wdata", a_wdata, 32'hDEAD_BEEF);
    chk1("e_dbgw_we", e_we, 1'b1);
    tick();

    dbg_we = 1'b0;
    #1;
    chk1("dbgr_gnt", a_gnt, 1'b1);
    chkw("dbgr_raddr", 32'(a_raddr), 32'd5);
    chk1("dbgr_we", a_we, 1'b0);
    chk1("dbgw_no_err", a_derr, 1'b0);
    tick();

    #1;
    chk1("dbgr_rvalid", a_rvalid, 1'b1);
    chkw("dbgr_rdata", a_rdata, 32'hDEAD_BEEF);
    chk1("dbgr_busy_gnt", a_gnt, 1'b0);
    chk1("dbgr_err", a_derr, 1'b0);
    chkw("e_dbgr_rdata", e_rdata, 32'hCAFE_F00D);
    tick();

    #1;
    chk1("dbgr2_gnt", a_gnt, 1'b1);
    chk1("dbgr2_rvalid_low", a_rvalid, 1'b0);
    tick();

    halted = 1'b0; dbg_req = 1'b0;
    #1;
    chk1("dbgr2_rvalid_unhalted", a_rvalid, 1'b1);
    chkw("dbgr2_rdata", a_rdata, 32'hDEAD_BEEF);
    tick();

    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6;
    #1;
    chk1("pend_gnt", a_gnt, 1'b0);
    chk1("pend_rvalid", a_rvalid, 1'b0);
    chkw("rdata_hold", a_rdata, 32'hDEAD_BEEF);
    tick();

    halted = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h1111;
    #1;
    chk1("x0w_gnt", a_gnt, 1'b1);
    chk1("x0w_we", a_we, 1'b0);
    chk1("e_x0w_we", e_we, 1'b0);
    tick();

    dbg_we = 1'b0; dbg_addr = 5'd20;
    #1;
    chk1("x20r_gnt", a_gnt, 1'b1);
    chk1("e_x20r_gnt", e_gnt, 1'b1);
    chkw("x20r_raddr", 32'(a_raddr), 32'd20);
    chk1("x0w_no_err", a_derr, 1'b0);
    tick();

    dbg_req = 1'b0;
    #1;
    chk1("e_x20r_rvalid", e_rvalid, 1'b1);
    chkw("e_x20r_rdata", e_rdata, EZero);
    chk1("e_x20r_err", e_derr, 1'b1);
    chkw("a_x20r_rdata", a_rdata, 32'h0);
    chk1("a_x20r_err", a_derr, 1'b0);
    tick();

    dbg_req = 1'b1; dbg_we = 1'b1; dbg_wdata = 32'h2222;
    #1;
    chk1("e_x20w_gnt", e_gnt, 1'b1);
    chk1("e_x20w_we", e_we, 1'b0);
    chk1("a_x20w_we", a_we, 1'b1);
    tick();

    dbg_req = 1'b0;
    #1;
    chk1("e_x20w_err", e_derr, 1'b1);
    chk1("e_x20w_rvalid", e_rvalid, 1'b0);
    chk1("a_x20w_err", a_derr, 1'b0);
    tick();

    #1;
    chk1("e_err_pulse_end", e_derr, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
    #1;
    chk1("e_x0r_gnt", e_gnt, 1'b1);
    tick();

    dbg_req = 1'b0;
    #1;
    chkw("e_x0r_rdata", e_rdata, EZero);
    chk1("e_x0r_err", e_derr, 1'b0);
    tick();

    dbg_req = 1'b1; dbg_addr = 5'd9;
    tick();
    dbg_req = 1'b0;
    #1;
    chkw("a_x9r_rdata", a_rdata, 32'h55);
    tick();

    // Reset in sweep cycle 10 restarts the sweep from x1
    rst_n = 1'b0;
    #1;
    chk1("rst2_done", a_done, 1'b0);
    chk1("rst2_err", a_err, 1'b0);
    chk1("rst2_rvalid", a_rvalid, 1'b0);
    chk1("e_rst2_done", e_done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chkw($sformatf("part_waddr_%0d", c), 32'(a_waddr), 32'(c));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chkw("rst3_waddr", 32'(a_waddr), 32'd1);
    chk1("rst3_done", a_done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      #1;
      chk1($sformatf("resweep_we_%0d", c), a_we, 1'b1);
      chkw($sformatf("resweep_waddr_%0d", c), 32'(a_waddr), 32'(c));
      chk1($sformatf("resweep_done_%0d", c), a_done, 1'b0);
      tick();
    end
    #1;
    chk1("resweep_done_after", a_done, 1'b1);
    chk1("resweep_err_clear", a_err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
